// File: rtl/alu_pkg.sv
// alu_pkg: opcode/funct constants and FSM state type shared by the execute-stage ALU
package alu_pkg;
    localparam logic [4:0] R_type       = 5'b01100;
    localparam logic [4:0] I_type       = 5'b00100;
    localparam logic [4:0] I_type_load  = 5'b00000;
    localparam logic [4:0] S_type       = 5'b01000;
    localparam logic [4:0] B_type       = 5'b11000;
    localparam logic [4:0] U_type_lui   = 5'b01101;
    localparam logic [4:0] U_type_auipc = 5'b00101;
    localparam logic [4:0] J_type_jal   = 5'b11011;
    localparam logic [4:0] I_type_jalr  = 5'b11001;
    localparam logic [2:0] Add  = 3'b000;
    localparam logic [2:0] Sll  = 3'b001;
    localparam logic [2:0] Slt  = 3'b010;
    localparam logic [2:0] Sltu = 3'b011;
    localparam logic [2:0] Xor  = 3'b100;
    localparam logic [2:0] Sr   = 3'b101;
    localparam logic [2:0] Or   = 3'b110;
    localparam logic [2:0] And  = 3'b111;
    localparam logic [2:0] Beq  = 3'b000;
    localparam logic [2:0] Bne  = 3'b001;
    localparam logic [2:0] Blt  = 3'b100;
    localparam logic [2:0] Bge  = 3'b101;
    localparam logic [2:0] Bltu = 3'b110;
    localparam logic [2:0] Bgeu = 3'b111;
    localparam logic [2:0] Mul    = 3'b000;
    localparam logic [2:0] Mulh   = 3'b001;
    localparam logic [2:0] Mulhsu = 3'b010;
    localparam logic [2:0] Mulhu  = 3'b011;
    localparam logic [2:0] Div    = 3'b100;
    localparam logic [2:0] Divu   = 3'b101;
    localparam logic [2:0] Rem    = 3'b110;
    localparam logic [2:0] Remu   = 3'b111;
    localparam logic [6:0] M_func7 = 7'b0000001;
    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: valid/ready operation and result channels of the execute-stage ALU
interface alu_seq_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_out;
    modport master (
        output in_valid, opcode, func3, func7, operand1, operand2, out_ready,
        input  in_ready, out_valid, alu_out
    );
    modport slave (
        input  in_valid, opcode, func3, func7, operand1, operand2, out_ready,
        output in_ready, out_valid, alu_out
    );
endinterface

// File: rtl/alu_seq_muldiv_iter.sv
// muldiv_iter: one-bit-per-step shift-add multiplier / restoring divider on magnitudes,
// with the sign fix-up and half selection applied combinationally on res_o.
module muldiv_iter import alu_pkg::*; #(parameter int XLEN = 32) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            last_o,
    output logic [XLEN-1:0] res_o
);
    localparam int CW = $clog2(XLEN);
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, step_val, prod;
    logic [XLEN-1:0]   div_q, div_d, a_abs, b_abs, dq;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d, a_neg, b_neg;
    logic [XLEN:0]     sum, trial;
    assign a_neg = a_i[XLEN-1] && (op_i inside {Mul, Mulh, Mulhsu, Div, Rem});
    assign b_neg = b_i[XLEN-1] && (op_i inside {Mul, Mulh, Div, Rem});
    assign a_abs = a_neg ? -a_i : a_i;
    assign b_abs = b_neg ? -b_i : b_i;
    // acc holds {partial product, multiplier} or {partial remainder, quotient}
    assign sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, div_q} : '0);
    assign trial    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, div_q};
    assign step_val = op_q[2] ? (trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                             : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                              : {sum, acc_q[XLEN-1:1]};
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        div_d = div_q;
        op_d  = op_q;
        neg_d = neg_q;
        if (start_i) begin
            cnt_d = '0;
            acc_d = {{XLEN{1'b0}}, a_abs};
            div_d = b_abs;
            op_d  = op_i;
            neg_d = (op_i inside {Rem, Remu}) ? a_neg : a_neg ^ b_neg;
        end else if (step_i) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = step_val;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
            div_q <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            div_q <= div_d;
            op_q  <= op_d;
            neg_q <= neg_d;
        end
    end
    assign last_o = cnt_q == CW'(XLEN-1);
    assign prod   = neg_q ? -acc_q : acc_q;
    assign dq     = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    assign res_o  = op_q[2] ? (neg_q ? -dq : dq)
                            : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked RV32IM execute ALU; base ops and division corner cases finish in
// one cycle, other M ops run through muldiv_iter (XLEN steps plus a fix-up cycle).
module alu_seq import alu_pkg::*; #(parameter int XLEN = 32) (
    input logic       clk,
    input logic       rst,
    input logic       flush,
    alu_seq_if.slave  bus
);
    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    state_t          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d, op1, op2, arith, base_res, spec_res, md_res, sra_r;
    logic [SW-1:0]   shamt;
    logic            alt, slt, sltu, eq, br_taken, is_m, div_zero, div_ovf, special, start, last;
    assign op1   = bus.operand1;
    assign op2   = bus.operand2;
    assign shamt = op2[SW-1:0];
    assign alt   = bus.func7[5];
    assign sra_r = $signed(op1) >>> shamt;
    assign slt   = $signed(op1) < $signed(op2);
    assign sltu  = op1 < op2;
    assign eq    = op1 == op2;
    always_comb begin
        arith = '0;
        case (bus.func3)
            Add:  arith = (bus.opcode == R_type && alt) ? op1 - op2 : op1 + op2;
            Sll:  arith = op1 << shamt;
            Slt:  arith = {{(XLEN-1){1'b0}}, slt};
            Sltu: arith = {{(XLEN-1){1'b0}}, sltu};
            Xor:  arith = op1 ^ op2;
            Sr:   arith = alt ? sra_r : op1 >> shamt;
            Or:   arith = op1 | op2;
            And:  arith = op1 & op2;
            default: arith = '0;
        endcase
    end
    always_comb begin
        br_taken = 1'b0;
        case (bus.func3)
            Beq:  br_taken = eq;
            Bne:  br_taken = !eq;
            Blt:  br_taken = slt;
            Bge:  br_taken = !slt;
            Bltu: br_taken = sltu;
            Bgeu: br_taken = !sltu;
            default: br_taken = 1'b0;
        endcase
    end
    always_comb begin
        base_res = '0;
        case (bus.opcode)
            R_type, I_type:                      base_res = arith;
            I_type_load, S_type, U_type_auipc:   base_res = op1 + op2;
            U_type_lui:                          base_res = op2;
            J_type_jal, I_type_jalr:             base_res = op1 + XLEN'(4);
            B_type:                              base_res = {{(XLEN-1){1'b0}}, !br_taken};
            default:                             base_res = '0;
        endcase
    end
    // divisions by zero and signed overflow bypass the iterative engine
    assign is_m     = bus.opcode == R_type && bus.func7 == M_func7;
    assign div_zero = op2 == '0;
    assign div_ovf  = !bus.func3[0] && op1 == MIN && op2 == '1;
    assign special  = is_m && bus.func3[2] && (div_zero || div_ovf);
    assign spec_res = div_zero ? (bus.func3[1] ? op1 : '1) : (bus.func3[1] ? '0 : op1);
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        start   = 1'b0;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                if (is_m && !special) begin
                    start   = 1'b1;
                    state_d = BUSY;
                end else begin
                    res_d   = special ? spec_res : base_res;
                    state_d = DONE;
                end
            end
            BUSY: state_d = last ? FIX : BUSY;
            FIX: begin
                res_d   = md_res;
                state_d = DONE;
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            res_d   = res_q;
            start   = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end
    muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .step_i  (state_q == BUSY),
        .op_i    (bus.func3),
        .a_i     (op1),
        .b_i     (op2),
        .last_o  (last),
        .res_o   (md_res)
    );
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.alu_out   = res_q;
endmodule
